// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the data memory.
// Sub-word stores are turned into a read-modify-write of the full 32-bit word.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  wr0,
    input  logic [3:0]            be0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  wr1,
    input  logic [3:0]            be1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_data_in,
    output logic                  dmem_wr_en,
    input  logic [DATA_WIDTH-1:0] dmem_data_out
);

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t                state_q, next_state;
    logic                  last_q, last_d;
    logic                  id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic                  busy_q, busy_d;
    logic                  gnt0_c, gnt1_c;
    logic                  sel1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_wr;
    logic [3:0]            sel_be;
    logic [DATA_WIDTH-1:0] merged;
    logic                  partial;

    // Register all state and output registers; reset aborts any transaction.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            be_q      <= 4'h0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            wr_en_q   <= 1'b0;
            data_in_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= next_state;
            last_q    <= last_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            wr_en_q   <= wr_en_d;
            data_in_q <= data_in_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, arbitration and next values of the output registers.
    always_comb begin
        next_state = state_q;
        last_d     = last_q;
        id_d       = id_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        wr_en_d    = 1'b0;
        data_in_d  = data_in_q;
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        merged     = '0;

        // Under contention the port that was not granted last wins.
        sel1      = req1 && (!req0 || !last_q);
        sel_addr  = sel1 ? addr1  : addr0;
        sel_wdata = sel1 ? wdata1 : wdata0;
        sel_wr    = sel1 ? wr1    : wr0;
        sel_be    = sel1 ? be1    : be0;
        partial   = wr_q && (be_q != 4'h0) && (be_q != 4'hF);

        for (int i = 0; i < int'(NUM_LANES); i++) begin
            merged[i*LANE_W +: LANE_W] = be_q[i] ? wdata_q[i*LANE_W +: LANE_W]
                                                 : dmem_data_out[i*LANE_W +: LANE_W];
        end

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt0_c     = !sel1;
                    gnt1_c     = sel1;
                    last_d     = sel1;
                    id_d       = sel1;
                    addr_d     = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d    = sel_wdata;
                    wr_d       = sel_wr;
                    be_d       = sel_be;
                    next_state = ACCESS;
                    if (sel_wr && (sel_be == 4'hF)) begin
                        wr_en_d   = 1'b1;
                        data_in_d = sel_wdata;
                    end
                end
            end
            ACCESS: begin
                rdata_d = dmem_data_out;
                if (partial) begin
                    wr_en_d    = 1'b1;
                    data_in_d  = merged;
                    next_state = WRITE;
                end else begin
                    rvalid0_d  = !id_q;
                    rvalid1_d  = id_q;
                    next_state = RESP;
                end
            end
            WRITE: begin
                rvalid0_d  = !id_q;
                rvalid1_d  = id_q;
                next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        busy_d = (next_state != IDLE);
    end

    assign gnt0         = gnt0_c && nrst;
    assign gnt1         = gnt1_c && nrst;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign dmem_addr    = addr_q;
    assign dmem_data_in = data_in_q;
    assign dmem_wr_en   = wr_en_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory behind it.
module tb_dmem_arbiter;

    logic        clk;
    logic        nrst;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        wr0, wr1;
    logic [3:0]  be0, be1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy, dmem_wr_en;
    logic [31:0] rdata, dmem_addr, dmem_data_in, dmem_data_out;

    logic [31:0] mem [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_data;

    int total;
    int bad;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .nrst(nrst),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .wr0(wr0), .be0(be0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .wr1(wr1), .be1(be1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy),
        .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in),
        .dmem_wr_en(dmem_wr_en), .dmem_data_out(dmem_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (dmem_wr_en) mem[dmem_addr[7:2]] <= dmem_data_in;
        else if (poke_en) mem[poke_idx] <= poke_data;
    end
    assign dmem_data_out = mem[dmem_addr[7:2]];

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = a[7:2]; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic drive(input int port, input logic r, input logic [31:0] a,
                         input logic w, input logic [3:0] b, input logic [31:0] d);
        if (port == 0) begin
            req0 = r; addr0 = a; wr0 = w; be0 = b; wdata0 = d;
        end else begin
            req1 = r; addr1 = a; wr1 = w; be1 = b; wdata1 = d;
        end
    endtask

    // One request from start to rvalid; lat is gnt-to-rvalid cycles, 99 on timeout.
    task automatic run_txn(input int port, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d,
                           output logic [31:0] rd, output int lat, output logic saw_wr);
        logic g, rv;
        lat = 99; rd = 32'h0; saw_wr = 1'b0;
        @(negedge clk);
        drive(port, 1'b1, a, w, b, d);
        #1;
        for (int k = 0; k < 5; k++) begin
            g = (port == 0) ? gnt0 : gnt1;
            if (g) break;
            @(negedge clk); #1;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) drive(port, 1'b0, a, w, b, d);
            #1;
            saw_wr = saw_wr | dmem_wr_en;
            rv = (port == 0) ? rvalid0 : rvalid1;
            if (rv) begin
                lat = k; rd = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        drive(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, busy, dmem_wr_en} !== 6'b0 ||
            rdata !== 32'h0 || dmem_addr !== 32'h0 || dmem_data_in !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b busy=%b wr_en=%b rdata=%h addr=%h din=%h, required all 0",
                     gnt0, gnt1, rvalid0, rvalid1, busy, dmem_wr_en, rdata, dmem_addr, dmem_data_in);
        end
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_load();
        poke(32'h10, 32'h44332211);
        poke(32'h20, 32'h12345678);
        @(negedge clk);
        drive(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        #1;
        total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL load_gnt: gnt0=%b gnt1=%b busy=%b, required 1 0 0", gnt0, gnt1, busy);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h10, 1'b0, 4'h0, 32'h0);
        #1;
        total++;
        if (dmem_wr_en !== 1'b0 || rvalid0 !== 1'b0 || busy !== 1'b1 || dmem_addr !== 32'h10) begin
            bad++; $display("FAIL load_t1: wr_en=%b rvalid0=%b busy=%b addr=%h, required 0 0 1 00000010",
                            dmem_wr_en, rvalid0, busy, dmem_addr);
        end
        @(negedge clk); #1;
        total++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'h44332211 || dmem_wr_en !== 1'b0) begin
            bad++; $display("FAIL load_t2: rvalid0=%b rvalid1=%b rdata=%h wr_en=%b, required 1 0 44332211 0",
                            rvalid0, rvalid1, rdata, dmem_wr_en);
        end
        @(negedge clk); #1;
        total++;
        if (rvalid0 !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL load_t3: rvalid0=%b busy=%b, required 0 0", rvalid0, busy);
        end
    endtask

    task automatic test_full_store();
        logic [31:0] rd;
        int          lat;
        logic        sw;
        @(negedge clk);
        drive(1, 1'b1, 32'h20, 1'b1, 4'hF, 32'hDEADBEEF);
        #1;
        total++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || dmem_wr_en !== 1'b0) begin
            bad++; $display("FAIL fstore_gnt: gnt1=%b gnt0=%b wr_en=%b, required 1 0 0", gnt1, gnt0, dmem_wr_en);
        end
        @(negedge clk);
        drive(1, 1'b0, 32'h20, 1'b1, 4'hF, 32'hDEADBEEF);
        #1;
        total++;
        if (dmem_wr_en !== 1'b1 || dmem_data_in !== 32'hDEADBEEF || dmem_addr !== 32'h20 || rvalid1 !== 1'b0) begin
            bad++; $display("FAIL fstore_t1: wr_en=%b din=%h addr=%h rvalid1=%b, required 1 deadbeef 00000020 0",
                            dmem_wr_en, dmem_data_in, dmem_addr, rvalid1);
        end
        @(negedge clk); #1;
        total++;
        if (dmem_wr_en !== 1'b0 || rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 32'h12345678) begin
            bad++; $display("FAIL fstore_t2: wr_en=%b rvalid1=%b rvalid0=%b rdata=%h, required 0 1 0 12345678",
                            dmem_wr_en, rvalid1, rvalid0, rdata);
        end
        run_txn(0, 32'h20, 1'b0, 4'h0, 32'h0, rd, lat, sw);
        total++;
        if (rd !== 32'hDEADBEEF || lat != 2 || sw !== 1'b0) begin
            bad++; $display("FAIL fstore_readback: rdata=%h lat=%0d wr_seen=%b, required deadbeef 2 0", rd, lat, sw);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd;
        int          lat;
        logic        sw;
        @(negedge clk);
        drive(0, 1'b1, 32'h10, 1'b1, 4'b0010, 32'h0000AB00);
        #1;
        total++;
        if (gnt0 !== 1'b1) begin
            bad++; $display("FAIL pstore_gnt: gnt0=%b, required 1", gnt0);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h10, 1'b1, 4'b0010, 32'h0000AB00);
        #1;
        total++;
        if (dmem_wr_en !== 1'b0 || rvalid0 !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL pstore_t1: wr_en=%b rvalid0=%b busy=%b, required 0 0 1", dmem_wr_en, rvalid0, busy);
        end
        @(negedge clk); #1;
        total++;
        if (dmem_wr_en !== 1'b1 || dmem_data_in !== 32'h4433AB11 || rvalid0 !== 1'b0) begin
            bad++; $display("FAIL pstore_t2: wr_en=%b din=%h rvalid0=%b, required 1 4433ab11 0",
                            dmem_wr_en, dmem_data_in, rvalid0);
        end
        @(negedge clk); #1;
        total++;
        if (dmem_wr_en !== 1'b0 || rvalid0 !== 1'b1 || rdata !== 32'h44332211) begin
            bad++; $display("FAIL pstore_t3: wr_en=%b rvalid0=%b rdata=%h, required 0 1 44332211",
                            dmem_wr_en, rvalid0, rdata);
        end
        run_txn(1, 32'h10, 1'b0, 4'h0, 32'h0, rd, lat, sw);
        total++;
        if (rd !== 32'h4433AB11 || lat != 2) begin
            bad++; $display("FAIL pstore_readback: rdata=%h lat=%0d, required 4433ab11 2", rd, lat);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        drive(0, 1'b1, 32'h13, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 32'h13, 1'b0, 4'h0, 32'h0);
        #1;
        total++;
        if (dmem_addr !== 32'h10) begin
            bad++; $display("FAIL misaligned_addr: dmem_addr=%h, required 00000010", dmem_addr);
        end
        @(negedge clk); #1;
        total++;
        if (rvalid0 !== 1'b1 || rdata !== 32'h4433AB11) begin
            bad++; $display("FAIL misaligned_data: rvalid0=%b rdata=%h, required 1 4433ab11", rvalid0, rdata);
        end
    endtask

    task automatic test_zero_be();
        logic [31:0] rd;
        int          lat;
        logic        sw;
        run_txn(1, 32'h20, 1'b1, 4'h0, 32'hFFFFFFFF, rd, lat, sw);
        total++;
        if (rd !== 32'hDEADBEEF || lat != 2 || sw !== 1'b0 || mem[8] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL zero_be: rdata=%h lat=%0d wr_seen=%b mem=%h, required deadbeef 2 0 deadbeef",
                            rd, lat, sw, mem[8]);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        drive(1, 1'b1, 32'h20, 1'b1, 4'b0001, 32'h000000AA);
        @(negedge clk);
        drive(1, 1'b0, 32'h20, 1'b1, 4'b0001, 32'h000000AA);
        @(negedge clk); #1;
        total++;
        if (dmem_wr_en !== 1'b1 || dmem_data_in !== 32'hDEADBEAA) begin
            bad++; $display("FAIL rmw_write_phase: wr_en=%b din=%h, required 1 deadbeaa", dmem_wr_en, dmem_data_in);
        end
        nrst = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, busy, dmem_wr_en} !== 6'b0 ||
            rdata !== 32'h0 || dmem_addr !== 32'h0 || dmem_data_in !== 32'h0) begin
            bad++; $display("FAIL rmw_reset_outputs: gnt=%b%b rvalid=%b%b busy=%b wr_en=%b rdata=%h addr=%h din=%h, required all 0",
                            gnt0, gnt1, rvalid0, rvalid1, busy, dmem_wr_en, rdata, dmem_addr, dmem_data_in);
        end
        @(negedge clk); #1;
        total++;
        if (mem[8] !== 32'hDEADBEEF || rvalid1 !== 1'b0) begin
            bad++; $display("FAIL rmw_reset_mem: mem=%h rvalid1=%b, required deadbeef 0", mem[8], rvalid1);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // Both ports keep requesting right after reset release: grants alternate from port 0.
    task automatic test_contention();
        int   order [$];
        logic seq_ok;
        logic both_gnt, both_rv, data_ok;
        both_gnt = 1'b0; both_rv = 1'b0; data_ok = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        for (int c = 0; c < 13; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (gnt0 && gnt1) both_gnt = 1'b1;
            if (rvalid0 && rvalid1) both_rv = 1'b1;
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
            if (rvalid0 && rdata !== 32'h4433AB11) data_ok = 1'b0;
            if (rvalid1 && rdata !== 32'hDEADBEEF) data_ok = 1'b0;
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (4) @(negedge clk);
        seq_ok = (order.size() == 5);
        for (int k = 0; k < order.size(); k++) if (order[k] != (k % 2)) seq_ok = 1'b0;
        total++;
        if (!seq_ok) begin
            bad++; $display("FAIL contention_order: %0d grants, first=%0d, required 5 grants alternating from port 0",
                            order.size(), (order.size() > 0) ? order[0] : -1);
        end
        total++;
        if (both_gnt || both_rv) begin
            bad++; $display("FAIL contention_exclusive: both_gnt=%b both_rvalid=%b, required 0 0", both_gnt, both_rv);
        end
        total++;
        if (!data_ok) begin
            bad++; $display("FAIL contention_data: rdata wrong on a response, required 4433ab11 for port0 and deadbeef for port1");
        end
    endtask

    initial begin
        total = 0; bad = 0;
        poke_en = 1'b0; poke_idx = 6'd0; poke_data = 32'h0;
        nrst = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        test_reset();
        test_load();
        test_full_store();
        test_partial_store();
        test_misaligned();
        test_zero_be();
        test_reset_mid_write();
        test_contention();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed data memory (`dmem`). It shares the single memory port between the core's load/store unit (port 0) and a secondary requester such as the debug/loader (port 1), using round-robin arbitration. It sequences each accepted request into memory cycles. Sub-word stores with byte enables become a read-modify-write, because the memory only writes full 32-bit words.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width on both requester ports and the memory side.
- `DATA_WIDTH`, 32, word width. Fixed at 32: four byte lanes.

Ports:
- `clk`  in  1  single clock, rising edge.
- `nrst`  in  1  reset. Asynchronous, active-low.
- `req0` / `req1`  in  1  request valid. Held, with its fields stable, until the matching `gnt` is seen.
- `addr0` / `addr1`  in  ADDR_WIDTH  byte address. `[1:0]` are ignored; accesses are word-aligned.
- `wdata0` / `wdata1`  in  DATA_WIDTH  store data, lane-aligned.
- `wr0` / `wr1`  in  1  1 = store, 0 = load.
- `be0` / `be1`  in  4  byte enables for stores. Bit i selects `wdata[8i+7:8i]`.
- `gnt0` / `gnt1`  out  1  one-cycle pulse in the cycle the request is accepted.
- `rvalid0` / `rvalid1`  out  1  one-cycle completion pulse to the granted port.
- `rdata`  out  DATA_WIDTH  response data, valid while `rvalid*` is high.
- `busy`  out  1  high whenever the state is not IDLE.
- `dmem_addr`  out  ADDR_WIDTH  to memory. Latched address with `[1:0]` forced to 0.
- `dmem_data_in`  out  DATA_WIDTH  to memory, write data.
- `dmem_wr_en`  out  1  to memory, write enable. The word is written at the rising edge.
- `dmem_data_out`  in  DATA_WIDTH  from memory, combinational read of `dmem_addr`.

## Operation
- The FSM has four states: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - If either `req` is high, select a winner, latch its addr/wdata/wr/be and its id, pulse its `gnt`, and go to ACCESS.
  - With no request, stay in IDLE.
- **Round-robin arbitration**
  - A `last` register records the port most recently granted.
  - When both ports request, grant the port that is not `last`.
  - When only one port requests, grant that port.
  - `last` resets to 1, so port 0 wins the first contention after reset.
- **ACCESS**: `dmem_addr` is driven from the latched address. The action depends on the request type:
  - Load: capture `dmem_data_out` into the `rdata` register, then go to RESP.
  - Store with `be` = 4'hF: drive `dmem_wr_en` = 1 and `dmem_data_in` = `wdata`. Also capture the old word into `rdata`. Go to RESP.
  - Store with a partial `be`: capture `dmem_data_out` into the merge/`rdata` register, then go to WRITE.
  - Store with `be` = 4'h0: no memory write. Capture the old word, then go to RESP.
- **WRITE**: drive `dmem_wr_en` = 1. `dmem_data_in` is the merged word: each byte lane i takes `wdata` if `be[i]` is set, else the captured byte. Go to RESP.
- **RESP**: pulse `rvalid` of the latched id for one cycle, with `rdata` valid. Go to IDLE.
  - For a load, `rdata` is the loaded word.
  - For a store, `rdata` is the pre-store word.
- One transaction is in flight at a time. `gnt` is only ever asserted in IDLE.
- `gnt0` and `gnt1` are never high together. Neither are `rvalid0` and `rvalid1`.
- Outside the ACCESS (full store) and WRITE cycles, `dmem_wr_en` = 0.
- `dmem_addr` holds the last latched address while in IDLE.

## Timing
- Latency is measured from the `gnt` cycle, T:
  - Load: `rvalid` in cycle T+2.
  - Full store: `dmem_wr_en` high in T+1 only; `rvalid` in T+2.
  - Partial store: read in T+1, `dmem_wr_en` high in T+2 only, `rvalid` in T+3.
- A new grant is possible at the earliest in the cycle after RESP.
  - Peak rate is one load per 3 cycles.
  - A requester that keeps `req` high after its `rvalid` is treated as issuing a new request.
- **Reset values** (`nrst` low): state = IDLE, `last` = 1, and all latched registers = 0. All outputs are 0:
  - `gnt*`, `rvalid*`, `rdata`, `busy`
  - `dmem_addr`, `dmem_data_in`, `dmem_wr_en`
- **Reset mid-transaction**: asserting reset aborts the transaction immediately, because the reset is asynchronous.
  - If asserted during WRITE before the edge, the pending write is dropped and the memory is unchanged.
  - No `rvalid` is issued for the aborted request.
- `req` arriving in the same cycle as RESP is not granted until IDLE.

## Test plan
- **Load**: memory bytes 0x10..0x13 = 11,22,33,44. Port 0 loads 0x10 → `gnt0` at T, `rvalid0` at T+2, `rdata` = 0x44332211, `dmem_wr_en` never high.
- **Full store**: port 1 stores 0xDEADBEEF, `be` = F, to 0x20 → `dmem_wr_en` high exactly in T+1, `rvalid1` at T+2. A following load of 0x20 returns 0xDEADBEEF.
- **Partial store**: word at 0x10 = 0x44332211. Store `wdata` = 0x0000AB00 with `be` = 4'b0010 → `dmem_wr_en` high only in T+2, `dmem_data_in` = 0x4433AB11, `rvalid` at T+3. A following load returns 0x4433AB11.
- **Contention**: both ports request loads continuously from reset → grants go 0,1,0,1. No simultaneous `gnt` and no simultaneous `rvalid`.
- **Misaligned address**: load at 0x13 → `dmem_addr` = 0x10 and returns the word at 0x10.
- **Reset mid-write**: partial store to 0x20; drop `nrst` during WRITE before the edge → memory at 0x20 unchanged, all outputs 0, no `rvalid`. After release, a port 0 request is granted first.
